// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage: register file with write-back bypass, RAW scoreboard,
// and a one-entry valid/ready output register feeding the ALU.
module operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        in_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic [31:0] rs_value,
  output logic [31:0] rt_value,
  output logic [31:0] imm,
  output logic [1:0]  ALUOp,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [31:0] regs [32];
  logic [31:0] busy;
  logic [31:0] busy_next;

  logic [5:0]  opcode;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic        use_rs;
  logic        use_rt;
  logic        has_dest;
  logic [4:0]  dest_dec;
  logic [1:0]  alu_op_dec;
  logic        reg_write_dec;
  logic [31:0] imm_dec;
  logic [31:0] rs_read;
  logic [31:0] rt_read;
  logic        rs_hazard;
  logic        rt_hazard;
  logic        hazard;
  logic        capture;

  assign opcode  = instr[31:26];
  assign rs_idx  = instr[25:21];
  assign rt_idx  = instr[20:16];
  assign rd_idx  = instr[15:11];
  assign imm_dec = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    has_dest   = 1'b0;
    dest_dec   = 5'd0;
    alu_op_dec = 2'b11;
    unique case (opcode)
      OP_RTYPE: begin
        use_rs     = 1'b1;
        use_rt     = 1'b1;
        has_dest   = 1'b1;
        dest_dec   = rd_idx;
        alu_op_dec = 2'b10;
      end
      OP_LW: begin
        use_rs     = 1'b1;
        has_dest   = 1'b1;
        dest_dec   = rt_idx;
        alu_op_dec = 2'b00;
      end
      OP_SW: begin
        use_rs     = 1'b1;
        use_rt     = 1'b1;
        alu_op_dec = 2'b00;
      end
      OP_BEQ: begin
        use_rs     = 1'b1;
        use_rt     = 1'b1;
        alu_op_dec = 2'b01;
      end
      default: begin
      end
    endcase
    reg_write_dec = has_dest && (dest_dec != 5'd0);
  end

  // Same-cycle write-back is forwarded so a dependent read never waits a cycle.
  always_comb begin
    rs_read = regs[rs_idx];
    if (rs_idx == 5'd0)
      rs_read = '0;
    else if (wb_en && (wb_reg == rs_idx))
      rs_read = wb_data;

    rt_read = regs[rt_idx];
    if (rt_idx == 5'd0)
      rt_read = '0;
    else if (wb_en && (wb_reg == rt_idx))
      rt_read = wb_data;
  end

  always_comb begin
    rs_hazard = use_rs && (rs_idx != 5'd0) && busy[rs_idx] &&
                !(wb_en && (wb_reg == rs_idx));
    rt_hazard = use_rt && (rt_idx != 5'd0) && busy[rt_idx] &&
                !(wb_en && (wb_reg == rt_idx));
    hazard    = rs_hazard || rt_hazard;
  end

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign capture  = instr_valid && in_ready;

  // Clear first, then set, so a capture targeting the register being written back stays busy.
  always_comb begin
    busy_next = busy;
    if (wb_en)
      busy_next[wb_reg] = 1'b0;
    if (capture && reg_write_dec)
      busy_next[dest_dec] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wb_en && (wb_reg != 5'd0)) begin
      regs[wb_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rs_value  <= '0;
      rt_value  <= '0;
      imm       <= '0;
      ALUOp     <= 2'b00;
      dest_reg  <= 5'd0;
      reg_write <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      rs_value  <= rs_read;
      rt_value  <= rt_read;
      imm       <= imm_dec;
      ALUOp     <= alu_op_dec;
      dest_reg  <= dest_dec;
      reg_write <= reg_write_dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
